axis_latency_stamper: RTL and testbench



---
 rtl/axis_latency_stamper.sv | 192 +++++++++++++++++++
 tb/tb_axis_latency_stamper.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_latency_stamper.sv
// axis_latency_stamper: egress stage between the user pipeline and the
// wrapper's s_axis_data port. It passes samples through a 2-entry registered
// skid buffer and rebuilds the 128-bit CHDR tuser once per packet from the
// SOP-time timer and a running sequence number. It can also measure
// per-packet pipeline latency as timer minus the ingress stamp in
// i_tuser[31:0].
// Build option: define LATENCY_STATS_EN to build the latency statistics.
// When it is not defined, the statistics outputs are tied to zero and
// clear_stats is ignored.
module axis_latency_stamper #(
    parameter int DATA_W = 32,
    parameter int LAT_W  = 32
) (
    input  logic              ce_clk,
    input  logic              reset,
    input  logic              clear_tx_seqnum,
    input  logic              clear_stats,
    input  logic [63:0]       timer,
    input  logic [15:0]       src_sid,
    input  logic [15:0]       next_dst_sid,
    input  logic [DATA_W-1:0] i_tdata,
    input  logic              i_tlast,
    input  logic              i_tvalid,
    output logic              i_tready,
    input  logic [127:0]      i_tuser,
    output logic [DATA_W-1:0] o_tdata,
    output logic              o_tlast,
    output logic              o_tvalid,
    input  logic              o_tready,
    output logic [127:0]      o_tuser,
    output logic [LAT_W-1:0]  lat_last,
    output logic [LAT_W-1:0]  lat_min,
    output logic [LAT_W-1:0]  lat_max,
    output logic [31:0]       pkt_count,
    output logic              lat_valid
);

    logic              in_fire;
    logic              sop_q;
    logic [11:0]       seqnum_q, seqnum_d;
    logic [127:0]      hdr_q;
    logic [127:0]      hdr_now;
    logic [127:0]      beat_tuser;

    logic              out_vld_q;
    logic [DATA_W-1:0] out_data_q;
    logic              out_last_q;
    logic [127:0]      out_user_q;
    logic              skid_vld_q;
    logic [DATA_W-1:0] skid_data_q;
    logic              skid_last_q;
    logic [127:0]      skid_user_q;

    // Ready depends only on the skid register, never on o_tready.
    // It is held low while reset is asserted.
    assign i_tready = !skid_vld_q && reset;
    assign in_fire  = i_tvalid && i_tready;

    // The SOP beat takes the live header. Later beats reuse the header that
    // was latched at SOP, so the whole packet carries one constant tuser.
    assign hdr_now    = {2'b00, 1'b1, 1'b0, seqnum_q, 16'h0000, src_sid, next_dst_sid, timer};
    assign beat_tuser = sop_q ? hdr_now : hdr_q;

    assign o_tvalid = out_vld_q;
    assign o_tdata  = out_data_q;
    assign o_tlast  = out_last_q;
    assign o_tuser  = out_user_q;

    // Next sequence number. A clear wins over a simultaneous tlast increment.
    always_comb begin
        seqnum_d = seqnum_q;
        if (clear_tx_seqnum)
            seqnum_d = 12'd0;
        else if (in_fire && i_tlast)
            seqnum_d = seqnum_q + 12'd1;
    end

    // Packet framing: SOP flag, latched header and sequence counter.
    always_ff @(posedge ce_clk or negedge reset) begin
        if (!reset) begin
            sop_q    <= 1'b1;
            hdr_q    <= '0;
            seqnum_q <= '0;
        end else begin
            seqnum_q <= seqnum_d;
            if (in_fire) begin
                sop_q <= i_tlast;
                if (sop_q)
                    hdr_q <= hdr_now;
            end
        end
    end

    // Two-entry skid buffer. The main register feeds the output. The skid
    // register catches the beat that was accepted while the output stalled.
    always_ff @(posedge ce_clk or negedge reset) begin
        if (!reset) begin
            out_vld_q   <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_user_q  <= '0;
            skid_vld_q  <= 1'b0;
            skid_data_q <= '0;
            skid_last_q <= 1'b0;
            skid_user_q <= '0;
        end else if (!out_vld_q || o_tready) begin
            if (skid_vld_q) begin
                out_vld_q  <= 1'b1;
                out_data_q <= skid_data_q;
                out_last_q <= skid_last_q;
                out_user_q <= skid_user_q;
                skid_vld_q <= 1'b0;
            end else if (in_fire) begin
                out_vld_q  <= 1'b1;
                out_data_q <= i_tdata;
                out_last_q <= i_tlast;
                out_user_q <= beat_tuser;
            end else begin
                out_vld_q  <= 1'b0;
            end
        end else if (in_fire) begin
            skid_vld_q  <= 1'b1;
            skid_data_q <= i_tdata;
            skid_last_q <= i_tlast;
            skid_user_q <= beat_tuser;
        end
    end

`ifdef LATENCY_STATS_EN
    logic             sop_fire;
    logic [LAT_W-1:0] lat;
    logic [LAT_W-1:0] lat_last_q, lat_min_q, lat_max_q;
    logic [31:0]      pkt_count_q;
    logic             lat_valid_q;
    logic             unused_tuser;

    assign sop_fire     = in_fire && sop_q;
    // Modulo subtraction, so a wrap of the timer between stamp and egress
    // still yields the correct latency.
    assign lat          = timer[LAT_W-1:0] - i_tuser[LAT_W-1:0];
    assign unused_tuser = ^i_tuser[127:LAT_W];

    assign lat_last  = lat_last_q;
    assign lat_min   = lat_min_q;
    assign lat_max   = lat_max_q;
    assign pkt_count = pkt_count_q;
    assign lat_valid = lat_valid_q;

    // Latency statistics. A clear that coincides with an SOP restarts the
    // statistics from that sample.
    always_ff @(posedge ce_clk or negedge reset) begin
        if (!reset) begin
            lat_last_q  <= '0;
            lat_min_q   <= '1;
            lat_max_q   <= '0;
            pkt_count_q <= '0;
            lat_valid_q <= 1'b0;
        end else begin
            lat_valid_q <= sop_fire;
            if (sop_fire && clear_stats) begin
                lat_last_q  <= lat;
                lat_min_q   <= lat;
                lat_max_q   <= lat;
                pkt_count_q <= 32'd1;
            end else if (clear_stats) begin
                lat_last_q  <= '0;
                lat_min_q   <= '1;
                lat_max_q   <= '0;
                pkt_count_q <= '0;
            end else if (sop_fire) begin
                lat_last_q <= lat;
                if (lat < lat_min_q)
                    lat_min_q <= lat;
                if (lat > lat_max_q)
                    lat_max_q <= lat;
                if (pkt_count_q != 32'hFFFF_FFFF)
                    pkt_count_q <= pkt_count_q + 32'd1;
            end
        end
    end
`else
    logic unused_stats;

    assign unused_stats = ^{clear_stats, i_tuser};
    assign lat_last     = '0;
    assign lat_min      = '0;
    assign lat_max      = '0;
    assign pkt_count    = '0;
    assign lat_valid    = 1'b0;
`endif

endmodule

// File: tb/tb_axis_latency_stamper.sv
// Scoreboard bench for axis_latency_stamper. Each accepted input beat pushes
// its expected output beat (data, last, rebuilt tuser) into a queue. The
// queue is popped and compared as output beats are accepted. A reference
// model of the latency statistics is compared every cycle.
module tb_axis_latency_stamper;

`ifdef LATENCY_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic         ce_clk;
    logic         reset;
    logic         clear_tx_seqnum;
    logic         clear_stats;
    logic [63:0]  timer;
    logic [15:0]  src_sid;
    logic [15:0]  next_dst_sid;
    logic [31:0]  i_tdata;
    logic         i_tlast;
    logic         i_tvalid;
    logic         i_tready;
    logic [127:0] i_tuser;
    logic [31:0]  o_tdata;
    logic         o_tlast;
    logic         o_tvalid;
    logic         o_tready;
    logic [127:0] o_tuser;
    logic [31:0]  lat_last;
    logic [31:0]  lat_min;
    logic [31:0]  lat_max;
    logic [31:0]  pkt_count;
    logic         lat_valid;

    axis_latency_stamper #(.DATA_W(32), .LAT_W(32)) dut (
        .ce_clk(ce_clk), .reset(reset),
        .clear_tx_seqnum(clear_tx_seqnum), .clear_stats(clear_stats),
        .timer(timer), .src_sid(src_sid), .next_dst_sid(next_dst_sid),
        .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid),
        .i_tready(i_tready), .i_tuser(i_tuser),
        .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tvalid(o_tvalid),
        .o_tready(o_tready), .o_tuser(o_tuser),
        .lat_last(lat_last), .lat_min(lat_min), .lat_max(lat_max),
        .pkt_count(pkt_count), .lat_valid(lat_valid)
    );

    initial ce_clk = 1'b0;
    always #5 ce_clk = ~ce_clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    typedef struct packed {
        logic [31:0]  d;
        logic         l;
        logic [127:0] u;
    } beat_t;

    beat_t        sb[$];
    bit           m_sop  = 1'b1;
    logic [11:0]  m_seq  = '0;
    logic [127:0] m_hdr  = '0;
    logic [31:0]  e_last = '0;
    logic [31:0]  e_min  = STATS ? 32'hFFFF_FFFF : 32'h0;
    logic [31:0]  e_max  = '0;
    logic [31:0]  e_cnt  = '0;
    bit           pend   = 1'b0;
    bit           prev_stall = 1'b0;
    beat_t        prev_beat;
    int           lv_count = 0;
    int           pops = 0;
    logic [127:0] last_out_u = '0;
    bit           bp = 1'b0;

    // Output-ready generator: always ready, or a 50% coin flip each cycle.
    initial begin
        o_tready = 1'b1;
        forever begin
            @(posedge ce_clk);
            #1;
            o_tready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor and reference model, sampled on the falling edge.
    always @(negedge ce_clk) begin
        beat_t        b;
        beat_t        e;
        logic [127:0] h;
        logic [31:0]  lat;
        bit           fire;
        if (!reset) begin
            m_sop = 1'b1; m_seq = '0; m_hdr = '0; sb.delete();
            e_last = '0; e_min = STATS ? 32'hFFFF_FFFF : 32'h0; e_max = '0; e_cnt = '0;
            pend = 1'b0; prev_stall = 1'b0;
        end
        if (lat_valid || pend) chk("lat_valid", lat_valid, pend);
        if (lat_valid) lv_count++;
        chk("lat_last", lat_last, e_last);
        chk("lat_min", lat_min, e_min);
        chk("lat_max", lat_max, e_max);
        chk("pkt_count", pkt_count, e_cnt);
        b = '{d: o_tdata, l: o_tlast, u: o_tuser};
        if (prev_stall) begin
            chk("hold_vld", o_tvalid, 1'b1);
            chk("hold_beat", b, prev_beat);
        end
        if (reset) begin
            if (o_tvalid && o_tready) begin
                if (sb.size() == 0) begin
                    chk("spurious_out", 1'b1, 1'b0);
                end else begin
                    e = sb.pop_front();
                    chk("out_data", o_tdata, e.d);
                    chk("out_last", o_tlast, e.l);
                    chk("out_tuser", o_tuser, e.u);
                    last_out_u = o_tuser;
                    pops++;
                end
            end
            prev_stall = o_tvalid && !o_tready;
            prev_beat  = b;
            pend = 1'b0;
            fire = i_tvalid && i_tready;
            if (fire) begin
                if (m_sop) begin
                    h = {2'b00, 1'b1, 1'b0, m_seq, 16'h0000, src_sid, next_dst_sid, timer};
                    m_hdr = h;
                end else begin
                    h = m_hdr;
                end
                sb.push_back('{d: i_tdata, l: i_tlast, u: h});
            end
            if (STATS) begin
                lat = timer[31:0] - i_tuser[31:0];
                if (fire && m_sop) begin
                    pend = 1'b1;
                    if (clear_stats) begin
                        e_last = lat; e_min = lat; e_max = lat; e_cnt = 1;
                    end else begin
                        e_last = lat;
                        if (lat < e_min) e_min = lat;
                        if (lat > e_max) e_max = lat;
                        if (e_cnt != 32'hFFFF_FFFF) e_cnt = e_cnt + 1;
                    end
                end else if (clear_stats) begin
                    e_last = '0; e_min = 32'hFFFF_FFFF; e_max = '0; e_cnt = '0;
                end
            end
            if (clear_tx_seqnum) m_seq = '0;
            else if (fire && i_tlast) m_seq = m_seq + 12'd1;
            if (fire) m_sop = i_tlast;
        end
    end

    // Offers one beat; entered and left just after a rising edge.
    task automatic send_beat(input logic [31:0] d, input logic l, input logic [31:0] stamp);
        int n;
        n = 0;
        i_tdata  = d;
        i_tlast  = l;
        i_tuser  = {$urandom, $urandom, $urandom, stamp};
        i_tvalid = 1'b1;
        forever begin
            @(negedge ce_clk);
            if (i_tready) break;
            n++;
            if (n > 200) begin
                chk("tready_timeout", 1'b1, 1'b0);
                break;
            end
        end
        @(posedge ce_clk);
        #1;
        i_tvalid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 1000) begin
            @(posedge ce_clk);
            n++;
        end
        chk("drain", sb.size(), 0);
        @(posedge ce_clk);
        #1;
    endtask

    initial begin
        int lv0;
        int p0;
        int lats[3];
        reset = 1'b0; clear_tx_seqnum = 1'b0; clear_stats = 1'b0;
        timer = '0; src_sid = 16'hA5A5; next_dst_sid = 16'h1234;
        i_tdata = '0; i_tlast = 1'b0; i_tvalid = 1'b0; i_tuser = '0;
        repeat (3) @(posedge ce_clk);
        #1;
        chk("rst_tvalid", o_tvalid, 1'b0);
        chk("rst_tdata", o_tdata, 32'h0);
        chk("rst_tlast", o_tlast, 1'b0);
        chk("rst_tuser", o_tuser, 128'h0);
        chk("rst_tready", i_tready, 1'b0);
        chk("rst_lat_min", lat_min, STATS ? 32'hFFFF_FFFF : 32'h0);
        chk("rst_lat_valid", lat_valid, 1'b0);
        reset = 1'b1;
        #1;
        chk("rel_tready", i_tready, 1'b1);
        @(posedge ce_clk);
        #1;

        // Single 4-beat packet, SOP at timer 0x100 with stamp 0xF0.
        lv0 = lv_count;
        for (int i = 0; i < 4; i++) begin
            timer = 64'h100 + 64'(i);
            send_beat(32'h1000 + 32'(i), i == 3, i == 0 ? 32'hF0 : 32'(i * 77));
        end
        drain();
        chk("p1_ts", last_out_u[63:0], 64'h100);
        chk("p1_seq", last_out_u[123:112], 12'd0);
        chk("p1_last", lat_last, STATS ? 32'h10 : 32'h0);
        chk("p1_min", lat_min, STATS ? 32'h10 : 32'h0);
        chk("p1_max", lat_max, STATS ? 32'h10 : 32'h0);
        chk("p1_cnt", pkt_count, STATS ? 32'd1 : 32'd0);
        chk("p1_lv_pulses", lv_count - lv0, STATS ? 1 : 0);

        // Latency across a 32-bit timer wrap.
        timer = 64'h1_0000_0005;
        send_beat(32'hCAFE, 1'b1, 32'hFFFF_FFFB);
        chk("wrap_lat", lat_last, STATS ? 32'h0A : 32'h0);
        drain();

        // Min/max/count, then a clear coincident with an SOP.
        clear_stats = 1'b1;
        @(posedge ce_clk); #1;
        clear_stats = 1'b0;
        lats = '{20, 5, 50};
        for (int i = 0; i < 3; i++) begin
            timer = 64'd1000 + 64'(i * 10);
            send_beat(32'(i), 1'b1, timer[31:0] - 32'(lats[i]));
        end
        chk("st_min", lat_min, STATS ? 32'd5 : 32'd0);
        chk("st_max", lat_max, STATS ? 32'd50 : 32'd0);
        chk("st_cnt", pkt_count, STATS ? 32'd3 : 32'd0);
        timer = 64'd2000;
        clear_stats = 1'b1;
        send_beat(32'h77, 1'b1, 32'd2000 - 32'd7);
        clear_stats = 1'b0;
        chk("clr_min", lat_min, STATS ? 32'd7 : 32'd0);
        chk("clr_max", lat_max, STATS ? 32'd7 : 32'd0);
        chk("clr_last", lat_last, STATS ? 32'd7 : 32'd0);
        chk("clr_cnt", pkt_count, STATS ? 32'd1 : 32'd0);
        drain();

        // Sequence wrap: 4097 single-beat packets starting from seqnum 0.
        clear_tx_seqnum = 1'b1;
        @(posedge ce_clk); #1;
        clear_tx_seqnum = 1'b0;
        p0 = pops;
        for (int i = 0; i < 4097; i++) begin
            timer = 64'h2_0000 + 64'(i);
            send_beat(32'(i), 1'b1, 32'h0);
        end
        drain();
        chk("seq_pops", pops - p0, 4097);
        chk("seq_wrap", last_out_u[123:112], 12'd0);
        clear_tx_seqnum = 1'b1;
        send_beat(32'hAB, 1'b1, 32'h0);
        clear_tx_seqnum = 1'b0;
        send_beat(32'hAC, 1'b1, 32'h0);
        drain();
        chk("seq_clear", last_out_u[123:112], 12'd0);

        // 32-beat packet under random output backpressure.
        bp = 1'b1;
        p0 = pops;
        timer = 64'h3_0000;
        for (int i = 0; i < 32; i++) begin
            send_beat(32'(i * 3 + 7), i == 31, 32'h2_FFF0);
            timer = timer + 1;
        end
        drain();
        bp = 1'b0;
        repeat (2) @(posedge ce_clk);
        #1;
        chk("bp_pops", pops - p0, 32);
        chk("bp_ts", last_out_u[63:0], 64'h3_0000);

        // Reset on beat 2 of a 6-beat packet.
        timer = 64'h5000;
        send_beat(32'h600, 1'b0, 32'h4FF0);
        send_beat(32'h601, 1'b0, 32'h0);
        reset = 1'b0;
        @(negedge ce_clk);
        chk("mr_tvalid", o_tvalid, 1'b0);
        chk("mr_tdata", o_tdata, 32'h0);
        chk("mr_tuser", o_tuser, 128'h0);
        chk("mr_tready", i_tready, 1'b0);
        chk("mr_cnt", pkt_count, 32'h0);
        @(posedge ce_clk); #1;
        reset = 1'b1;
        lv0 = lv_count;
        timer = 64'h6000;
        for (int i = 2; i < 6; i++) begin
            send_beat(32'h600 + 32'(i), i == 5, i == 2 ? 32'h5FF0 : 32'h0);
            timer = timer + 1;
        end
        drain();
        chk("mr_ts", last_out_u[63:0], 64'h6000);
        chk("mr_seq", last_out_u[123:112], 12'd0);
        chk("mr_lat", lat_last, STATS ? 32'h10 : 32'h0);
        chk("mr_lv_pulses", lv_count - lv0, STATS ? 1 : 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        chk("watchdog", 1'b1, 1'b0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
